// File: rtl/sr_debounce_pkg.sv
// Shared constants for the SR pushbutton debouncer: per-channel FSM state
// encoding and default parameter values.
package sr_debounce_pkg;

    localparam logic [1:0] ST_LOW    = 2'd0;
    localparam logic [1:0] ST_CHK_HI = 2'd1;
    localparam logic [1:0] ST_HIGH   = 2'd2;
    localparam logic [1:0] ST_CHK_LO = 2'd3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_CNT_W           = 16;

endpackage

// File: rtl/sr_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, LOW/CHK_HI/HIGH/CHK_LO FSM with a
// saturating stability counter, registered debounced level and accept strobe.
module sr_debounce_chan
    import sr_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic strobe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             sync1;
    logic             sync2;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lvl_nxt;
    logic             strobe_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The counter holds the number of consecutive agreeing samples seen so far
    // in a CHK state; any disagreeing sample aborts back to the stable state.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        strobe_nxt = 1'b0;
        case (state)
            ST_LOW: begin
                if (sync2) begin
                    state_nxt = ST_CHK_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_CHK_HI: begin
                if (sync2) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt  = ST_HIGH;
                        cnt_nxt    = '0;
                        strobe_nxt = 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end
            end
            ST_HIGH: begin
                if (!sync2) begin
                    state_nxt = ST_CHK_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_CHK_LO: begin
                if (!sync2) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_LOW;
                        cnt_nxt   = '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
        lvl_nxt = (state_nxt == ST_HIGH) || (state_nxt == ST_CHK_LO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_LOW;
            cnt    <= '0;
            lvl    <= 1'b0;
            strobe <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            lvl    <= lvl_nxt;
            strobe <= strobe_nxt;
        end
    end

endmodule

// File: rtl/sr_debounce.sv
// Dual pushbutton debouncer feeding a downstream SR flip-flop: one-cycle set and
// reset pulses, reset-dominant arbitration and a conflict flag.
module sr_debounce
    import sr_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic s_raw,
    input  logic r_raw,
    output logic s_out,
    output logic r_out,
    output logic s_lvl,
    output logic r_lvl,
    output logic conflict
);

    logic s_stb;
    logic r_stb;

    sr_debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_s_chan (
        .clk   (clk),
        .rst   (rst),
        .raw   (s_raw),
        .lvl   (s_lvl),
        .strobe(s_stb)
    );

    sr_debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_r_chan (
        .clk   (clk),
        .rst   (rst),
        .raw   (r_raw),
        .lvl   (r_lvl),
        .strobe(r_stb)
    );

    // Reset dominates so the SR flip-flop never sees s and r together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_out    <= 1'b0;
            r_out    <= 1'b0;
            conflict <= 1'b0;
        end else begin
            s_out    <= s_stb & ~r_stb;
            r_out    <= r_stb;
            conflict <= s_stb & r_stb;
        end
    end

endmodule
